// File: rtl/dram_pixel_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dram_pixel_reader: streams a contiguous DRAM range into a valid/ready     |
// | pixel stream through a small FIFO.                      Revision: 1.0     |
// +--------------------------------------------------------------------------+
module dram_pixel_reader #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_din,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    count_d;
  logic              done_q;
  logic              push;
  logic              pop;

  // Push uses registered occupancy only, so a same-cycle pop never frees a slot early.
  assign push = (state_q == S_READ) && (remaining_q != '0) && (count_q != FULL_CNT);
  assign pop  = (count_q != '0) && pix_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q    <= wr_ptr_q + 1'b1;
        mem_addr_q  <= mem_addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mem_addr_q  <= base_addr;
            remaining_q <= length;
            state_q     <= S_READ;
          end
        end
        S_READ: begin
          if (remaining_q == '0) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (count_q == '0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign pix_data  = fifo_q[rd_ptr_q];
  assign pix_valid = (count_q != '0);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_pixel_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dram_pixel_reader: directed bench for dram_pixel_reader.               |
// | DRAM model returns mem[k] = k mod 512.                  Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_dram_pixel_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [17:0] base_addr;
  logic [18:0] length;
  logic [17:0] mem_addr;
  logic [8:0]  mem_din;
  logic [8:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int first_c;
  int done_c;
  int npix;

  dram_pixel_reader #(
    .ADDR_W    (18),
    .DATA_W    (9),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .pix_data (pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .busy     (busy),
    .done     (done)
  );

  assign mem_din = mem_addr[8:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Modes: 0 ready high, 1 ready low in cycles 2..9, 2 random ready,
  // 3 ready high with a stray start in cycle 5, 4 reset asserted in cycle 20.
  task automatic xfer(input string tag, input logic [17:0] b, input logic [18:0] n,
                      input int mode, input int budget,
                      output int fc, output int dc, output int np);
    logic [17:0] a;
    bit fin;
    base_addr = b;
    length    = n;
    start     = 1'b1;
    tick();
    start = 1'b0;
    fc = -1; dc = -1; np = 0; fin = 1'b0;
    chk($sformatf("%s.busy_c1", tag), {31'd0, busy}, 32'd1);
    chk($sformatf("%s.addr_c1", tag), {14'd0, mem_addr}, {14'd0, b});
    chk($sformatf("%s.done_c1", tag), {31'd0, done}, 32'd0);
    for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
      start = 1'b0;
      case (mode)
        1:       pix_ready = !(cyc >= 2 && cyc <= 9);
        2:       pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = 1'b1;
      endcase
      if (mode == 3 && cyc == 5) begin
        start     = 1'b1;
        base_addr = 18'h00100;
        length    = 19'd3;
      end
      if (pix_valid) begin
        a = b + 18'(np);
        chk($sformatf("%s.pix%0d", tag, np), {23'd0, pix_data}, {23'd0, a[8:0]});
        if (fc < 0) fc = cyc;
        if (pix_ready) np++;
      end
      if (mode == 1 && cyc == 9) begin
        chk($sformatf("%s.stall_addr", tag), {14'd0, mem_addr}, 32'h14);
      end
      if (done) begin
        dc = cyc;
        chk($sformatf("%s.busy_at_done", tag), {31'd0, busy}, 32'd0);
        fin = 1'b1;
      end else if (mode == 4 && cyc == 20) begin
        rst = 1'b1;
        tick();
        chk($sformatf("%s.rst_addr", tag), {14'd0, mem_addr}, 32'd0);
        chk($sformatf("%s.rst_valid", tag), {31'd0, pix_valid}, 32'd0);
        chk($sformatf("%s.rst_busy", tag), {31'd0, busy}, 32'd0);
        chk($sformatf("%s.rst_done", tag), {31'd0, done}, 32'd0);
        rst = 1'b0;
        fin = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    pix_ready = 1'b0;
    repeat (3) tick();
    chk("reset.addr", {14'd0, mem_addr}, 32'd0);
    chk("reset.valid", {31'd0, pix_valid}, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick();

    xfer("rstmid", 18'h0, 19'd100, 4, 200, first_c, done_c, npix);
    chk("rstmid.no_done_in_xfer", done_c, -1);
    repeat (4) begin
      tick();
      chk("rstmid.done_after", {31'd0, done}, 32'd0);
      chk("rstmid.busy_after", {31'd0, busy}, 32'd0);
    end

    xfer("seq", 18'h10, 19'd8, 0, 50, first_c, done_c, npix);
    chk("seq.first_cycle", first_c, 2);
    chk("seq.done_cycle", done_c, 11);
    chk("seq.npix", npix, 8);

    xfer("stall", 18'h10, 19'd8, 1, 60, first_c, done_c, npix);
    chk("stall.npix", npix, 8);
    chk("stall.done_seen", {31'd0, done_c > 0}, 32'd1);

    xfer("wrap", 18'h3FFFE, 19'd4, 0, 50, first_c, done_c, npix);
    chk("wrap.npix", npix, 4);
    chk("wrap.done_cycle", done_c, 7);

    xfer("len0", 18'h55, 19'd0, 0, 20, first_c, done_c, npix);
    chk("len0.npix", npix, 0);
    chk("len0.first", first_c, -1);
    chk("len0.done_cycle", done_c, 3);

    xfer("restart", 18'h20, 19'd16, 3, 60, first_c, done_c, npix);
    chk("restart.npix", npix, 16);
    chk("restart.done_cycle", done_c, 19);

    xfer("rand", 18'h3FE00, 19'd1024, 2, 6000, first_c, done_c, npix);
    chk("rand.npix", npix, 1024);
    chk("rand.done_seen", {31'd0, done_c > 0}, 32'd1);

    tick();
    chk("end.done", {31'd0, done}, 32'd0);
    chk("end.busy", {31'd0, busy}, 32'd0);
    chk("end.valid", {31'd0, pix_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
